uart_mem_loader: RTL and testbench

- Upstream feeder for the dual-port program/data RAM of the VSCPU.
- Receives a framed program image over RS232 (8N1) and writes 32-bit words into RAM port B.
- Holds the CPU in reset/stall while a load is in progress.
- Contains its own UART receiver, byte assembler and load state machine.

---
 rtl/uart_mem_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_mem_loader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_loader.sv
// Serial program loader: 8N1 receiver, byte assembler and load FSM writing
// 32-bit words into RAM port B while holding the CPU off.
module uart_mem_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DEPTH        = 512,
    parameter int unsigned ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              cpu_hold,
    output logic              busy,
    output logic              load_done,
    output logic              frame_err
);

    localparam int unsigned     CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]      HDR       = 8'h55;
    localparam logic [16:0]     DEPTH_W   = 17'(DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, DONE} ld_state_e;

    logic             rx_meta_q, rx_sync_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             armed_q, armed_d;
    logic             byte_valid_q, byte_valid_d;
    logic             byte_bad_q, byte_bad_d;

    ld_state_e        ld_state_q, ld_state_d;
    logic [15:0]      count_q, count_d;
    logic [15:0]      count_w;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      word_q, word_d;
    logic             mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]      mem_din_q, mem_din_d;
    logic             hold_q, hold_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            armed_q      <= 1'b0;
            byte_valid_q <= 1'b0;
            byte_bad_q   <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            armed_q      <= armed_d;
            byte_valid_q <= byte_valid_d;
            byte_bad_q   <= byte_bad_d;
        end
    end

    // A start is only armed after the line has been seen high in RX_IDLE,
    // so a low stop bit cannot retrigger reception.
    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q + CNT_W'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        armed_d      = armed_q;
        byte_valid_d = 1'b0;
        byte_bad_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (rx_sync_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d    = 1'b0;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        byte_bad_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state_q <= IDLE;
            count_q    <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            hold_q     <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign count_w = {count_q[15:8], shift_q};

    always_comb begin
        ld_state_d = ld_state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        hold_d     = hold_q;
        err_d      = err_q;
        done_d     = 1'b0;
        case (ld_state_q)
            IDLE: begin
                if (byte_valid_q && shift_q == HDR) begin
                    err_d      = 1'b0;
                    hold_d     = 1'b1;
                    idx_d      = '0;
                    byte_cnt_d = '0;
                    ld_state_d = CNT_HI;
                end
            end
            CNT_HI: begin
                if (byte_bad_q) begin
                    err_d      = 1'b1;
                    hold_d     = 1'b0;
                    ld_state_d = IDLE;
                end else if (byte_valid_q) begin
                    count_d[15:8] = shift_q;
                    ld_state_d    = CNT_LO;
                end
            end
            CNT_LO: begin
                if (byte_bad_q) begin
                    err_d      = 1'b1;
                    hold_d     = 1'b0;
                    ld_state_d = IDLE;
                end else if (byte_valid_q) begin
                    count_d = count_w;
                    if (count_w[15:10] != '0 || {1'b0, count_w} > DEPTH_W) begin
                        err_d      = 1'b1;
                        hold_d     = 1'b0;
                        ld_state_d = IDLE;
                    end else if (count_w == '0) begin
                        ld_state_d = DONE;
                    end else begin
                        ld_state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (byte_bad_q) begin
                    err_d      = 1'b1;
                    hold_d     = 1'b0;
                    ld_state_d = IDLE;
                end else if (byte_valid_q) begin
                    word_d     = {word_q[23:0], shift_q};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d   = 1'b1;
                        mem_din_d  = {word_q[23:0], shift_q};
                        mem_addr_d = idx_q;
                        idx_d      = idx_q + ADDR_W'(1);
                        if (16'(idx_q) == count_q - 16'd1) begin
                            ld_state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                done_d     = 1'b1;
                hold_d     = 1'b0;
                ld_state_d = IDLE;
            end
            default: ld_state_d = IDLE;
        endcase
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign cpu_hold  = hold_q;
    assign busy      = (ld_state_q != IDLE);
    assign load_done = done_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader: per-byte vector table plus hand-written
// glitch, abort and mid-load reset sequences.
module tb_uart_mem_loader;

    localparam int unsigned CPB = 16;
    localparam int unsigned GAP = 12;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic        cpu_hold;
    logic        busy;
    logic        load_done;
    logic        frame_err;

    uart_mem_loader #(
        .CLKS_PER_BIT(CPB),
        .DEPTH(512),
        .ADDR_W(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_din(mem_din),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .load_done(load_done),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       busy;
        logic       hold;
        logic       err;
        int         wr;
        int         dn;
    } vec_t;

    vec_t        tbl[$];
    logic [9:0]  got_addr[$];
    logic [31:0] got_data[$];
    logic [9:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    int          n_dones  = 0;
    int          bad_done = 0;
    int          n_cmp    = 0;
    int          n_err    = 0;
    logic [7:0]  f1[11];

    always @(negedge clk) begin
        if (mem_we) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_din);
        end
        if (load_done) begin
            n_dones++;
            if (cpu_hold || busy) bad_done++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic glitch();
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic add(input logic [7:0] d, input logic s, input logic b, input logic h,
                       input logic e, input int w, input int dn);
        tbl.push_back('{d, s, b, h, e, w, dn});
    endtask

    task automatic add_frame1(input int w0, input int d0);
        add(8'h55, 1, 1, 1, 0, w0, d0);
        add(8'h00, 1, 1, 1, 0, w0, d0);
        add(8'h02, 1, 1, 1, 0, w0, d0);
        add(8'hDE, 1, 1, 1, 0, w0, d0);
        add(8'hAD, 1, 1, 1, 0, w0, d0);
        add(8'hBE, 1, 1, 1, 0, w0, d0);
        add(8'hEF, 1, 1, 1, 0, w0 + 1, d0);
        add(8'h01, 1, 1, 1, 0, w0 + 1, d0);
        add(8'h02, 1, 1, 1, 0, w0 + 1, d0);
        add(8'h03, 1, 1, 1, 0, w0 + 1, d0);
        add(8'h04, 1, 0, 0, 0, w0 + 2, d0 + 1);
    endtask

    task automatic exp_frame1();
        exp_addr.push_back(10'd0); exp_data.push_back(32'hDEADBEEF);
        exp_addr.push_back(10'd1); exp_data.push_back(32'h01020304);
    endtask

    initial begin
        f1 = '{8'h55, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};

        // scenario 1, then leading junk and a repeat of the frame
        add_frame1(0, 0);
        add(8'h00, 1, 0, 0, 0, 2, 1);
        add(8'hFF, 1, 0, 0, 0, 2, 1);
        add(8'h12, 1, 0, 0, 0, 2, 1);
        add_frame1(2, 1);
        // abort on a bad stop bit mid-word, trailing bytes ignored
        add(8'h55, 1, 1, 1, 0, 4, 2);
        add(8'h00, 1, 1, 1, 0, 4, 2);
        add(8'h01, 1, 1, 1, 0, 4, 2);
        add(8'hAA, 1, 1, 1, 0, 4, 2);
        add(8'h33, 0, 0, 0, 1, 4, 2);
        add(8'hBB, 1, 0, 0, 1, 4, 2);
        add(8'hCC, 1, 0, 0, 1, 4, 2);
        // header clears the error; zero count completes immediately
        add(8'h55, 1, 1, 1, 0, 4, 2);
        add(8'h00, 1, 1, 1, 0, 4, 2);
        add(8'h00, 1, 0, 0, 0, 4, 3);
        // 0x55 inside the data phase is payload
        add(8'h55, 1, 1, 1, 0, 4, 3);
        add(8'h00, 1, 1, 1, 0, 4, 3);
        add(8'h01, 1, 1, 1, 0, 4, 3);
        add(8'h55, 1, 1, 1, 0, 4, 3);
        add(8'h55, 1, 1, 1, 0, 4, 3);
        add(8'h00, 1, 1, 1, 0, 4, 3);
        add(8'h55, 1, 0, 0, 0, 5, 4);
        // count 513 rejected, then a bad byte in IDLE leaves the flag alone
        add(8'h55, 1, 1, 1, 0, 5, 4);
        add(8'h02, 1, 1, 1, 0, 5, 4);
        add(8'h01, 1, 0, 0, 1, 5, 4);
        add(8'hA5, 0, 0, 0, 1, 5, 4);

        exp_frame1();
        exp_frame1();
        exp_addr.push_back(10'd0); exp_data.push_back(32'h55550055);
        exp_frame1();
        exp_frame1();
        exp_frame1();

        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset cpu_hold", 32'(cpu_hold), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset frame_err", 32'(frame_err), 32'd0);
        chk("reset load_done", 32'(load_done), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < tbl.size(); v++) begin
            send_byte(tbl[v].data, tbl[v].stop);
            chk($sformatf("v%0d busy", v), 32'(busy), 32'(tbl[v].busy));
            chk($sformatf("v%0d cpu_hold", v), 32'(cpu_hold), 32'(tbl[v].hold));
            chk($sformatf("v%0d frame_err", v), 32'(frame_err), 32'(tbl[v].err));
            chk($sformatf("v%0d writes", v), 32'(got_addr.size()), 32'(tbl[v].wr));
            chk($sformatf("v%0d dones", v), 32'(n_dones), 32'(tbl[v].dn));
        end

        // short low pulse in IDLE is a glitch, not a start bit
        glitch();
        chk("glitch idle busy", 32'(busy), 32'd0);
        chk("glitch idle err", 32'(frame_err), 32'd1);
        for (int i = 0; i < 11; i++) send_byte(f1[i], 1'b1);
        chk("glitch idle writes", 32'(got_addr.size()), 32'd7);
        chk("glitch idle dones", 32'(n_dones), 32'd5);
        chk("glitch idle err clr", 32'(frame_err), 32'd0);

        // glitch between payload bytes must not shift a byte into the word
        for (int i = 0; i < 5; i++) send_byte(f1[i], 1'b1);
        glitch();
        chk("glitch data busy", 32'(busy), 32'd1);
        for (int i = 5; i < 11; i++) send_byte(f1[i], 1'b1);
        chk("glitch data writes", 32'(got_addr.size()), 32'd9);
        chk("glitch data dones", 32'(n_dones), 32'd6);

        // asynchronous reset after the second payload byte
        for (int i = 0; i < 5; i++) send_byte(f1[i], 1'b1);
        chk("pre-reset cpu_hold", 32'(cpu_hold), 32'd1);
        chk("pre-reset mem_addr", 32'(mem_addr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async mem_we", 32'(mem_we), 32'd0);
        chk("async mem_addr", 32'(mem_addr), 32'd0);
        chk("async mem_din", mem_din, 32'd0);
        chk("async cpu_hold", 32'(cpu_hold), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        chk("async load_done", 32'(load_done), 32'd0);
        chk("async frame_err", 32'(frame_err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 11; i++) send_byte(f1[i], 1'b1);
        chk("post-reset writes", 32'(got_addr.size()), 32'd11);
        chk("post-reset dones", 32'(n_dones), 32'd7);
        chk("post-reset cpu_hold", 32'(cpu_hold), 32'd0);

        chk("write count total", 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (i < got_addr.size()) begin
                chk($sformatf("w%0d addr", i), 32'(got_addr[i]), 32'(exp_addr[i]));
                chk($sformatf("w%0d data", i), got_data[i], exp_data[i]);
            end
        end
        chk("hold/busy at load_done", 32'(bad_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
